// File: rtl/strobe_bank.sv
// Multi-channel edge-strobe generator: optional synchroniser, glitch filter,
// per-channel edge-select strobe, sticky pending flag and saturating counter.
module strobe_bank #(
    parameter int CHANNELS           = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int FILTER_LEN         = 1,
    parameter int COUNT_WIDTH        = 8,
    parameter bit STROBE_AFTER_RESET = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             in,
    input  logic [2*CHANNELS-1:0]           mode,
    input  logic [CHANNELS-1:0]             clear,
    output logic [CHANNELS-1:0]             out,
    output logic [CHANNELS-1:0]             level,
    output logic [CHANNELS-1:0]             pending,
    output logic [CHANNELS*COUNT_WIDTH-1:0] count
);

    localparam int PW = (SYNC_STAGES > 0) ? $clog2(SYNC_STAGES + 1) : 1;
    localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RW-1:0]          RUN_LAST  = RW'(FILTER_LEN - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Shared prime window: holds every channel frozen until its synchroniser
    // has flushed, then lets level load the synchronised value once.
    logic [PW-1:0] prime_cnt;
    logic          primed;
    logic          prime_load;

    assign prime_load = !primed && (prime_cnt == PW'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_load) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + PW'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s;
        logic [1:0]    m;
        logic [RW-1:0] run;
        logic          level_q;
        logic          out_q;
        logic          pending_q;
        logic [COUNT_WIDTH-1:0] cnt_q;

        assign m = mode[2*i+1:2*i];

        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] chain;

            always_ff @(posedge clk) begin
                if (reset) begin
                    chain <= '0;
                end else begin
                    chain <= (chain << 1) | SYNC_STAGES'(in[i]);
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = in[i];
        end

        // The initial load behaves as if the prior level were ~s, so the
        // edge direction is simply given by s itself.
        always_ff @(posedge clk) begin
            if (reset) begin
                level_q <= 1'b0;
                out_q   <= 1'b0;
                run     <= '0;
            end else if (prime_load) begin
                level_q <= s;
                run     <= '0;
                out_q   <= STROBE_AFTER_RESET && (s ? m[0] : m[1]);
            end else if (!primed) begin
                out_q <= 1'b0;
            end else begin
                out_q <= 1'b0;
                if (s == level_q) begin
                    run <= '0;
                end else if (run == RUN_LAST) begin
                    level_q <= s;
                    run     <= '0;
                    out_q   <= s ? m[0] : m[1];
                end else begin
                    run <= run + RW'(1);
                end
            end
        end

        // A strobe coinciding with clear wins, so no event is ever lost.
        always_ff @(posedge clk) begin
            if (reset) begin
                pending_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                pending_q <= out_q | (pending_q & ~clear[i]);
                if (clear[i]) begin
                    cnt_q <= out_q ? COUNT_WIDTH'(1) : '0;
                end else if (out_q && (cnt_q != COUNT_MAX)) begin
                    cnt_q <= cnt_q + COUNT_WIDTH'(1);
                end
            end
        end

        assign out[i]     = out_q;
        assign level[i]   = level_q;
        assign pending[i] = pending_q;
        assign count[COUNT_WIDTH*i +: COUNT_WIDTH] = cnt_q;
    end

endmodule

// File: tb/tb_strobe_bank.sv
// Directed self-checking bench for strobe_bank: vector table for the rising
// edge and glitch cases, hand-written sequences for the multi-cycle corners.
module tb_strobe_bank;

    localparam int CH = 4;
    localparam int CW = 4;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   in_v;
    logic [2*CH-1:0] mode_v;
    logic [CH-1:0]   clear_v;

    logic [CH-1:0]    out_a, level_a, pending_a;
    logic [CH*CW-1:0] count_a;
    logic [CH-1:0]    out_b, level_b, pending_b;
    logic [CH*CW-1:0] count_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    strobe_bank #(
        .CHANNELS(CH), .SYNC_STAGES(2), .FILTER_LEN(3),
        .COUNT_WIDTH(CW), .STROBE_AFTER_RESET(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .in(in_v), .mode(mode_v), .clear(clear_v),
        .out(out_a), .level(level_a), .pending(pending_a), .count(count_a)
    );

    strobe_bank #(
        .CHANNELS(CH), .SYNC_STAGES(2), .FILTER_LEN(3),
        .COUNT_WIDTH(CW), .STROBE_AFTER_RESET(1'b1)
    ) dut_sar (
        .clk(clk), .reset(reset), .in(in_v), .mode(mode_v), .clear(clear_v),
        .out(out_b), .level(level_b), .pending(pending_b), .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [CH-1:0]    stim_in;
        logic [2*CH-1:0]  stim_mode;
        logic [CH-1:0]    stim_clear;
        logic [CH-1:0]    exp_out;
        logic [CH-1:0]    exp_level;
        logic [CH-1:0]    exp_pending;
        logic [CH*CW-1:0] exp_count;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_v    = v.stim_in;
        mode_v  = v.stim_mode;
        clear_v = v.stim_clear;
        tick();
    endtask

    // Drives a square wave on one channel and tallies what the strobe output does.
    task automatic runWave(input int periods, input int half, input int ch,
                           output int strobes, output int falls,
                           output int doubles, output int highs);
        logic prev;
        prev    = 1'b0;
        strobes = 0;
        falls   = 0;
        doubles = 0;
        highs   = 0;
        for (int p = 0; p < periods + 1; p++) begin
            for (int c = 0; c < 2 * half; c++) begin
                in_v[ch] = (p < periods) && (c < half);
                tick();
                if (out_a[ch]) begin
                    strobes++;
                    if (!level_a[ch]) falls++;
                    if (prev) doubles++;
                end
                if (level_a[ch]) highs++;
                prev = out_a[ch];
            end
        end
    endtask

    initial begin
        int strobes, falls, doubles, highs;

        vecs[0]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[1]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[2]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[3]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
        vecs[4]  = '{4'b0001, 8'h55, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 16'h0000};
        vecs[5]  = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 16'h0001};
        vecs[6]  = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 16'h0001};
        vecs[7]  = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 16'h0001};
        vecs[8]  = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 16'h0001};
        vecs[9]  = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 16'h0001};
        vecs[10] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[11] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[12] = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[13] = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        for (int i = 14; i < 19; i++)
            vecs[i] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        for (int i = 19; i < 22; i++)
            vecs[i] = '{4'b0010, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[22] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[23] = '{4'b0000, 8'h55, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 16'h0001};
        vecs[24] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 16'h0011};
        vecs[25] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 16'h0011};
        vecs[26] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 16'h0011};
        vecs[27] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 16'h0011};
        vecs[28] = '{4'b0000, 8'h55, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
        vecs[29] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 16'h0001};

        // Prime window with the input held through reset.
        reset   = 1'b1;
        in_v    = 4'b0101;
        mode_v  = 8'h55;
        clear_v = 4'b0000;
        tick();
        tick();
        checkOutput("rst.out", 32'(out_a), 32'h0);
        checkOutput("rst.level", 32'(level_a), 32'h0);
        checkOutput("rst.pending", 32'(pending_a), 32'h0);
        checkOutput("rst.count", 32'(count_a), 32'h0);
        checkOutput("rst.sar_out", 32'(out_b), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("prime1.out", 32'(out_a), 32'h0);
        checkOutput("prime1.level", 32'(level_a), 32'h0);
        checkOutput("prime1.sar_out", 32'(out_b), 32'h0);
        tick();
        checkOutput("prime2.level", 32'(level_a), 32'h0);
        checkOutput("prime2.sar_out", 32'(out_b), 32'h0);
        tick();
        checkOutput("prime3.out", 32'(out_a), 32'h0);
        checkOutput("prime3.level", 32'(level_a), 32'h5);
        checkOutput("prime3.sar_out", 32'(out_b), 32'h5);
        checkOutput("prime3.sar_level", 32'(level_b), 32'h5);
        checkOutput("prime3.sar_pending", 32'(pending_b), 32'h0);
        tick();
        checkOutput("prime4.sar_out", 32'(out_b), 32'h0);
        checkOutput("prime4.sar_pending", 32'(pending_b), 32'h5);
        checkOutput("prime4.sar_count", 32'(count_b), 32'h0101);
        checkOutput("prime4.pending", 32'(pending_a), 32'h0);
        checkOutput("prime4.count", 32'(count_a), 32'h0);

        // Fresh start with all inputs low.
        reset = 1'b1;
        in_v  = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d.out", i), 32'(out_a), 32'(vecs[i].exp_out));
            checkOutput($sformatf("row%0d.level", i), 32'(level_a), 32'(vecs[i].exp_level));
            checkOutput($sformatf("row%0d.pending", i), 32'(pending_a), 32'(vecs[i].exp_pending));
            checkOutput($sformatf("row%0d.count", i), 32'(count_a), 32'(vecs[i].exp_count));
        end

        // Mode switching on channel 2.
        mode_v = 8'h75;
        runWave(4, 5, 2, strobes, falls, doubles, highs);
        checkOutput("both.strobes", 32'(strobes), 32'd8);
        checkOutput("both.falls", 32'(falls), 32'd4);
        checkOutput("both.doubles", 32'(doubles), 32'd0);
        checkOutput("both.count", 32'(count_a[11:8]), 32'd8);
        checkOutput("both.pending", 32'(pending_a[2]), 32'd1);

        mode_v = 8'h65;
        runWave(4, 5, 2, strobes, falls, doubles, highs);
        checkOutput("fall.strobes", 32'(strobes), 32'd4);
        checkOutput("fall.falls", 32'(falls), 32'd4);
        checkOutput("fall.count", 32'(count_a[11:8]), 32'd12);

        mode_v = 8'h45;
        runWave(1, 5, 2, strobes, falls, doubles, highs);
        checkOutput("off.strobes", 32'(strobes), 32'd0);
        checkOutput("off.level_high", 32'(highs), 32'd5);
        checkOutput("off.level_end", 32'(level_a[2]), 32'd0);
        checkOutput("off.count", 32'(count_a[11:8]), 32'd12);

        // Saturation and clear on channel 3.
        runWave(20, 4, 3, strobes, falls, doubles, highs);
        checkOutput("sat.strobes", 32'(strobes), 32'd20);
        checkOutput("sat.count", 32'(count_a[15:12]), 32'd15);
        checkOutput("sat.pending", 32'(pending_a[3]), 32'd1);

        in_v[3] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("satclr.pre_out", 32'(out_a[3]), 32'd0);
        tick();
        checkOutput("satclr.out", 32'(out_a[3]), 32'd1);
        checkOutput("satclr.level", 32'(level_a[3]), 32'd1);
        clear_v = 4'b1000;
        tick();
        checkOutput("satclr.count", 32'(count_a[15:12]), 32'd1);
        checkOutput("satclr.pending", 32'(pending_a[3]), 32'd1);
        checkOutput("satclr.out_after", 32'(out_a[3]), 32'd0);
        tick();
        checkOutput("clr.count", 32'(count_a[15:12]), 32'd0);
        checkOutput("clr.pending", 32'(pending_a[3]), 32'd0);
        clear_v = 4'b0000;

        // Reset pulsed while channel 0 is two cycles into qualification.
        in_v = 4'b0000;
        for (int k = 0; k < 6; k++) tick();
        in_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("midq.out_pre", 32'(out_a), 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("midq.rst_out", 32'(out_a), 32'h0);
        checkOutput("midq.rst_level", 32'(level_a), 32'h0);
        checkOutput("midq.rst_count", 32'(count_a), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("midq.c1_out", 32'(out_a), 32'h0);
        checkOutput("midq.c1_level", 32'(level_a), 32'h0);
        tick();
        checkOutput("midq.c2_level", 32'(level_a), 32'h0);
        checkOutput("midq.c2_sar_out", 32'(out_b), 32'h0);
        tick();
        checkOutput("midq.c3_out", 32'(out_a), 32'h0);
        checkOutput("midq.c3_level", 32'(level_a), 32'h1);
        checkOutput("midq.c3_sar_out", 32'(out_b), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("midq.hold%0d_out", k), 32'(out_a), 32'h0);
            checkOutput($sformatf("midq.hold%0d_sar_out", k), 32'(out_b), 32'h0);
        end
        checkOutput("midq.pending", 32'(pending_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/strobe_bank.md
# strobe_bank

Multi-channel, parametrised edge-strobe generator for the GPS front-end and tracking control paths. Each channel optionally synchronises an asynchronous input and rejects glitches shorter than a programmable length. It emits a one-cycle strobe on the run-time-selected edge (rising, falling, both, or off). Per-channel sticky pending flags and saturating event counters let software and slower FSMs collect events without missing them.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; 0 means no synchroniser, and `in` is used directly.
- FILTER_LEN, 1: consecutive cycles a new value must hold before it is accepted; 1 means no filtering. Must be at least 1.
- COUNT_WIDTH, 8: width of each per-channel event counter.
- STROBE_AFTER_RESET, 0: if 1, the post-reset initial load may strobe (see Operation).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  CHANNELS  raw channel inputs.
- mode  in  2*CHANNELS  per-channel edge select, with [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both.
- clear  in  CHANNELS  per-channel clear of pending and count.
- out  out  CHANNELS  one-cycle strobe per accepted edge.
- level  out  CHANNELS  filtered, accepted input level.
- pending  out  CHANNELS  sticky flag: at least one strobe since the last clear.
- count  out  CHANNELS*COUNT_WIDTH  per-channel saturating strobe count, with [COUNT_WIDTH*(i+1)-1:COUNT_WIDTH*i] for channel i.

## Operation
- Reset (while reset=1):
  - Synchroniser flops, level, out, pending, count and filter run counters are all set to 0.
  - The prime counter is loaded with 0.
  - Any in-flight qualification is discarded.
- Synchroniser: SYNC_STAGES-deep shift chain per channel. Its last stage is `s[i]`; when SYNC_STAGES=0, `s[i]` is `in[i]`.
- Prime window: one shared counter of width clog2(SYNC_STAGES+1).
  - During cycles 0..SYNC_STAGES-1 after reset release, the filter and strobe logic are frozen.
  - At the edge ending cycle SYNC_STAGES, each `level[i]` loads `s[i]` directly, with no filtering.
  - If STROBE_AFTER_RESET=1, this load strobes as though the prior level were the complement of `s[i]`: rising mode strobes if `s[i]`=1, falling mode strobes if `s[i]`=0, both always strobes, off never strobes.
  - If STROBE_AFTER_RESET=0, this load never strobes.
- Filter, per channel, with run counter width max(1, clog2(FILTER_LEN)):
  - If `s`==`level`, run is set to 0.
  - Else if run==FILTER_LEN-1, `level` is set to `s` and run is set to 0. This is the accept.
  - Else run is incremented.
- Strobe:
  - On an accept, `out` is registered high for exactly the cycle in which the new `level` is first visible, if `mode` matches the edge direction: 0→1 is rising, 1→0 is falling.
  - Mode is sampled at the accepting edge; mode changes apply to the next accept.
  - `level` tracks the input even when mode=00.
- Pending:
  - Set on `out`; cleared on `clear`.
  - If set and clear happen in the same cycle, pending is set, so no event is lost.
- Count:
  - Incremented on `out` and saturates at 2^COUNT_WIDTH-1.
  - `clear` zeroes it.
  - If clear and out happen in the same cycle, count becomes 1.
- Channels are fully independent except for the shared prime counter.

## Timing
- All outputs are registered, and all are 0 during reset and in the first cycle after reset release.
- Latency: if `in` changes before edge 1 and is held, `level` and `out` update at edge SYNC_STAGES+FILTER_LEN.
- `out` is never high for two consecutive cycles on one channel when FILTER_LEN≥2. When FILTER_LEN=1 it can be high on consecutive cycles only if the input toggles every cycle and mode=11.
- A pulse shorter than FILTER_LEN cycles at `s` is never accepted, and its partial run is discarded.
- pending and count update one edge after `out` rises, so they are visible the cycle after the strobe.
- Reset asserted mid-qualification clears run. After release, a full prime window plus FILTER_LEN cycles are required before the next accept.

## Test plan
Default setup is CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=3, COUNT_WIDTH=4 unless stated.
- Rising edge: mode[1:0]=01; in[0] goes 0→1 before edge k and is held → out[0]=1 for one cycle after edge k+4, level[0] rises at the same time, next cycle pending[0]=1 and count[0]=1; in[0] then goes 1→0 → no strobe.
- Glitch filter: in[1] high for 2 cycles, mode 01 → no strobe, level[1] stays 0; in[1] high for 3 cycles → exactly one strobe.
- Mode switching: mode=11 on ch2, in[2] square wave with period 10 for 4 periods → 8 strobes, count[2]=8; then mode=10 for 4 periods → 4 more strobes, all on falling edges, count[2]=12; then mode=00 → no strobes, level still tracks.
- Saturation and clear: 20 rising edges on ch3 → count[3]=15, pending[3]=1; clear[3] in the same cycle as out[3] → count[3]=1, pending[3]=1; clear alone → count[3]=0, pending[3]=0.
- Prime and initial strobe: STROBE_AFTER_RESET=1, in=4'b0101 held through reset, mode=01 on all channels → out=0101 for one cycle, visible in cycle 3 after release, and level=0101. With STROBE_AFTER_RESET=0 → out stays 0 and level=0101.
- Reset mid-qualification: reset pulsed for 1 cycle while the run counter is 2 → no strobe follows until the input re-qualifies, i.e. after 2+3 cycles from release.
